// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between a pipeline request port and a
// word-organised data memory. Handles byte, halfword and word accesses. Loads
// return the selected lane, sign- or zero-extended. Byte and halfword stores
// are done as a read-modify-write of the containing word. Misaligned accesses
// and illegal size codes complete with an error and never touch memory.
//
// Ports
//   clk, rst_n            clock (posedge) / async active-low reset
//   req_valid, req_ready  request handshake; accept on valid && ready
//   req_we                1 = store, 0 = load
//   req_funct3            RISC-V size/sign code
//   req_addr, req_wdata   byte address, LSB-justified store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  extended load data, error flag
//   mem_addr              word-aligned memory address
//   mem_wdata, mem_we     memory write word / enable
//   mem_rdata             memory read word, captured at the end of RD
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request
// RD    | one-cycle memory read (load, or first half of sub-word store)
// WR    | one-cycle memory write
// RESP  | completion pulse, then back to IDLE
module dmem_lsu #(
  parameter int DATA_LENGTH      = 32,
  parameter int DMEM_ADDR_LENGTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [2:0]                  req_funct3,
  input  logic [DMEM_ADDR_LENGTH-1:0] req_addr,
  input  logic [DATA_LENGTH-1:0]      req_wdata,
  output logic                        resp_valid,
  output logic [DATA_LENGTH-1:0]      resp_rdata,
  output logic                        resp_err,
  output logic [DMEM_ADDR_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0]      mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_LENGTH-1:0]      mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state, state_nxt;

  logic                        we_q;
  logic [2:0]                  funct3_q;
  logic [DMEM_ADDR_LENGTH-1:0] addr_q;
  logic [DATA_LENGTH-1:0]      wdata_q;
  logic                        err_q;
  logic [DATA_LENGTH-1:0]      rdata_cap;

  logic accept;
  logic req_legal;
  logic req_misaligned;
  logic req_err;

  assign accept = (state == IDLE) && req_valid;

  // Size code 11 is never legal; loads additionally reject 110 (no "WU").
  assign req_legal = req_we ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11))
                            : ((req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]));

  assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign req_err = !req_legal || req_misaligned;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                        state_nxt = RESP;
          else if (!req_we)                   state_nxt = RD;
          else if (req_funct3[1:0] == 2'b10)  state_nxt = WR;
          else                                state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and read-word capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_cap <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
      end
      if (state == RD) rdata_cap <= mem_rdata;
    end
  end

  // Lane selection from the captured word
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [DATA_LENGTH-1:0] load_data;
  logic [DATA_LENGTH-1:0] store_word;

  assign byte_sel = rdata_cap[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = rdata_cap[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rdata_cap;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_LENGTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(DATA_LENGTH-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(DATA_LENGTH-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(DATA_LENGTH-16){1'b0}}, half_sel};
      default: load_data = rdata_cap;
    endcase
  end

  // Sub-word stores merge into the word read during RD; SW bypasses it.
  always_comb begin
    store_word = rdata_cap;
    case (funct3_q[1:0])
      2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state == IDLE);
    mem_we     = (state == WR);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = '0;
    if ((state == RESP) && !we_q && !err_q) resp_rdata = load_data;
  end

  assign mem_addr  = {addr_q[DMEM_ADDR_LENGTH-1:2], 2'b00};
  assign mem_wdata = store_word;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: directed scenarios followed by random requests,
// checked against a byte-lane reference model of the data memory.
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  dmem_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: samples the address on negedge, writes on negedge.
  logic [31:0] mem [64];
  logic        bk_we;
  logic [5:0]  bk_idx;
  logic [31:0] bk_data;

  always @(negedge clk) begin
    mem_rdata <= mem[mem_addr[7:2]];
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    if (bk_we)  mem[bk_idx] <= bk_data;
  end

  // Reference memory contents
  logic [31:0] ref_mem [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one request, and the memory update it implies.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output int lat, output int nwe, output logic [31:0] new_word);
    int size;
    int off;
    logic [31:0] mask;
    logic [31:0] word;
    bit legal;
    size  = 1 << f3[1:0];
    off   = int'(addr % 4);
    mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((addr % size) != 0);
    word  = ref_mem[addr[7:2]];
    rd    = 32'd0;
    nwe   = 0;
    new_word = word;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      rd = (word >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && rd[8 * size - 1]) rd = rd | ~mask;
      lat = 2;
    end else begin
      new_word = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      ref_mem[addr[7:2]] = new_word;
      lat = (size == 4) ? 2 : 3;
      nwe = 1;
    end
  endtask

  // Wait up to 6 cycles for the response, watching memory writes.
  task automatic collect(output int lat, output logic [31:0] rd, output logic err,
                         output int nwe, output logic [31:0] wa, output logic [31:0] wdat);
    lat = 0; rd = 'x; err = 1'bx; nwe = 0; wa = 'x; wdat = 'x;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_ready", {31'd0, req_ready}, 32'd0);
      if (mem_we) begin
        nwe++;
        wa   = mem_addr;
        wdat = mem_wdata;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        err = resp_err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    #1;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got_rd,
                        output int got_lat, output logic [31:0] got_wd);
    logic e_err, g_err;
    logic [31:0] e_rd, e_word, g_wa;
    int e_lat, e_nwe, g_nwe;
    model(we, f3, addr, wd, e_err, e_rd, e_lat, e_nwe, e_word);
    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after accept; a stray req_valid while busy must be ignored.
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_valid  = 1'($urandom_range(0, 1));
    collect(got_lat, got_rd, g_err, g_nwe, g_wa, got_wd);
    check("latency", 32'(got_lat), 32'(e_lat));
    check("resp_err", {31'd0, g_err}, {31'd0, e_err});
    check("resp_rdata", got_rd, e_rd);
    check("write_count", 32'(g_nwe), 32'(e_nwe));
    if (e_nwe != 0) begin
      check("wr_addr", g_wa, {addr[31:2], 2'b00});
      check("wr_data", got_wd, e_word);
    end
    check("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
  endtask

  initial begin
    logic [31:0] rd, wdat, a, am, rd2;
    logic        we_r;
    logic [2:0]  f3_r;
    int          lat, lat2;
    logic        e_err;
    logic [31:0] e_rd, e_word;
    int          e_lat, e_nwe;
    bit          saw_we;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; bk_we = 1'b0; bk_idx = 6'd0; bk_data = 32'd0;

    // Preload memory while in reset
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      bk_we   = 1'b1;
      bk_idx  = 6'(i);
      bk_data = (i == 2) ? 32'hAABB_CCDD : $urandom;
      ref_mem[i] = bk_data;
    end
    @(posedge clk);
    bk_we = 1'b0;

    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Sub-word loads from 0xAABBCCDD at 0x8
    do_req(1'b0, 3'b000, 32'h9, 32'h0, rd, lat, wdat);
    check("lb_0x9", rd, 32'hFFFF_FFCC);
    check("lb_lat", 32'(lat), 32'd2);
    do_req(1'b0, 3'b101, 32'hA, 32'h0, rd, lat, wdat);
    check("lhu_0xa", rd, 32'h0000_AABB);
    do_req(1'b0, 3'b100, 32'h8, 32'h0, rd, lat, wdat);
    check("lbu_0x8", rd, 32'h0000_00DD);

    // Halfword read-modify-write, then read back
    do_req(1'b1, 3'b001, 32'hA, 32'h0000_1234, rd, lat, wdat);
    check("sh_wdata", wdat, 32'h1234_CCDD);
    check("sh_lat", 32'(lat), 32'd3);
    do_req(1'b0, 3'b010, 32'h8, 32'h0, rd, lat, wdat);
    check("lw_after_sh", rd, 32'h1234_CCDD);

    // Errors
    do_req(1'b0, 3'b010, 32'h6, 32'h0, rd, lat, wdat);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_rdata", rd, 32'd0);
    do_req(1'b1, 3'b100, 32'h8, 32'h55, rd, lat, wdat);
    check("st_illegal_lat", 32'(lat), 32'd1);

    // Reset during the RD phase of an SB abandons the write
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h8; req_wdata = 32'hEE; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstrd_mem_we", {31'd0, mem_we}, 32'd0);
    check("rstrd_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstrd_mem_addr", mem_addr, 32'd0);
    check("rstrd_mem_wdata", mem_wdata, 32'd0);
    saw_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_we) saw_we = 1'b1;
    end
    check("rstrd_no_write", {31'd0, saw_we}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rstrd_ready", {31'd0, req_ready}, 32'd1);
    check("rstrd_word", mem[2], 32'h1234_CCDD);
    check("rstrd_word_model", mem[2], ref_mem[2]);

    // Back-to-back SW then LW with req_valid held high
    model(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, e_err, e_rd, e_lat, e_nwe, e_word);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (resp_valid) lat = c;
    end
    check("b2b_sw_lat", 32'(lat), 32'd2);
    @(negedge clk);
    check("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    model(1'b0, 3'b010, 32'h10, 32'h0, e_err, e_rd, e_lat, e_nwe, e_word);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat2 = 0; rd2 = 'x;
    for (int c = 1; c <= 6 && lat2 == 0; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat2 = c; rd2 = resp_rdata; end
    end
    check("b2b_lw_lat", 32'(lat2), 32'd2);
    check("b2b_lw_data", rd2, 32'hCAFE_F00D);
    check("b2b_lw_model", rd2, e_rd);

    // Random requests
    for (int n = 0; n < 120; n++) begin
      we_r = 1'($urandom_range(0, 1));
      f3_r = 3'($urandom_range(0, 7));
      a    = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        am = (32'd1 << f3_r[1:0]) - 32'd1;
        a  = a & ~am;
      end
      do_req(we_r, f3_r, a, $urandom, rd, lat, wdat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_LENGTH, 32, data word width.
- DMEM_ADDR_LENGTH, 32, byte-address width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, pipeline access request.
- req_ready, out, 1, block idle; request accepted when req_valid && req_ready at posedge.
- req_we, in, 1, 1 = store, 0 = load.
- req_funct3, in, 3, RISC-V size/sign code.
- req_addr, in, DMEM_ADDR_LENGTH, byte address.
- req_wdata, in, DATA_LENGTH, store data, LSB-justified.
- resp_valid, out, 1, one-cycle completion pulse.
- resp_rdata, out, DATA_LENGTH, extended load data.
- resp_err, out, 1, misaligned or illegal access.
- mem_addr, out, DMEM_ADDR_LENGTH, word-aligned address to data memory.
- mem_wdata, out, DATA_LENGTH, word written to memory.
- mem_we, out, 1, memory write enable.
- mem_rdata, in, DATA_LENGTH, memory read word, valid before the posedge that follows the negedge it was sampled on.

Function
REQ-003 mem_addr[1:0] SHALL always be 2'b00; mem_addr[DMEM_ADDR_LENGTH-1:2] = req_addr[DMEM_ADDR_LENGTH-1:2] of the accepted request.
REQ-004 FSM states SHALL be IDLE, RD, WR, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE.
REQ-006 funct3 decode SHALL be:
- 000 B (sign-extended)
- 001 H (sign-extended)
- 010 W
- 100 BU (zero-extended)
- 101 HU (zero-extended)
- Loads: any other code is illegal.
- Stores: only 000, 001 and 010 are legal.
REQ-007 Misalignment SHALL be:
- H/HU with addr[0]=1.
- W with addr[1:0]!=00.
REQ-008 Transitions on accept SHALL be:
- Illegal or misaligned: IDLE->RESP, resp_err=1, no memory access.
- Load: IDLE->RD.
- Word store: IDLE->WR.
- Byte or half store: IDLE->RD.
REQ-009 RD SHALL last exactly one cycle with mem_we=0 and SHALL register mem_rdata at its closing posedge.
- Load: RD->RESP.
- Sub-word store: RD->WR.
REQ-010 WR SHALL last exactly one cycle with mem_we=1.
- mem_wdata = req_wdata for SW.
- Otherwise mem_wdata = captured word with the selected byte lane (addr[1:0]) or halfword lane (addr[1]) replaced by req_wdata[7:0] or req_wdata[15:0].
- Then WR->RESP.
REQ-011 RESP SHALL last one cycle: resp_valid=1, then ->IDLE. resp_valid SHALL be 0 in all other states.
REQ-012 Latency from accept edge to the resp_valid cycle SHALL be:
- Error: 1 cycle.
- Load: 2 cycles.
- SW: 2 cycles.
- SB/SH: 3 cycles.
REQ-013 resp_rdata for loads SHALL be the selected lane, sign- or zero-extended to DATA_LENGTH.
REQ-014 resp_rdata SHALL be 0 for stores and errors.
REQ-015 mem_we SHALL be 1 only in WR.
REQ-016 Request fields SHALL be registered at accept; input changes after accept SHALL have no effect.
REQ-017 req_valid outside IDLE SHALL be ignored and not queued.
REQ-018 Back-to-back requests SHALL be accepted on the first IDLE cycle after RESP.

Reset
REQ-019 rst_n=0 SHALL immediately force:
- state=IDLE.
- mem_we=0, resp_valid=0, resp_err=0.
- resp_rdata=0, mem_addr=0, mem_wdata=0, capture register=0.
REQ-020 Reset asserted in RD or WR SHALL abandon the access with no partial write; an interrupted RMW leaves the memory word unchanged provided rst_n falls before the WR negedge.
REQ-021 First accept after reset release SHALL occur at the first posedge with rst_n=1 and req_valid=1.

Verification
REQ-022 Memory word 0x8 = 0xAABBCCDD; LB addr 0x9 -> resp_rdata=0xFFFFFFCC, resp_err=0, 2 cycles after accept.
REQ-023 Same word; LHU addr 0xA -> 0x0000AABB; LBU addr 0x8 -> 0x000000DD.
REQ-024 SH addr 0xA, wdata 0x00001234 -> one RD, one WR with mem_wdata=0x1234CCDD, mem_addr=0x8; following LW 0x8 returns 0x1234CCDD.
REQ-025 Misaligned and illegal accesses:
- LW addr 0x6 -> resp_err=1, resp_rdata=0, 1-cycle latency, mem_we never 1.
- Store with funct3=100 -> resp_err=1.
REQ-026 SB addr 0x8 wdata 0xEE with rst_n pulled low during RD -> mem_we stays 0, word 0x8 unchanged, req_ready=1 after release.
REQ-027 Back-to-back SW 0x10=0xCAFEF00D then LW 0x10 with req_valid held high -> second accept on first IDLE cycle, load returns 0xCAFEF00D.
